// File: rtl/riscv_defs.sv
// Shared core definitions: RAM geometry and memory-port owner encodings.
// Imported by the arbiter, the core stages and the RAM wrapper.
package riscv_defs;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_IF    = 2'd1,
    OWN_LS_RD = 2'd2,
    OWN_LS_WR = 2'd3
  } owner_e;

  function automatic logic owner_is_ls(owner_e o);
    return (o == OWN_LS_RD) || (o == OWN_LS_WR);
  endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating counter of consecutive LS grants that kept a waiting fetch out.
// Clear wins over increment; sat_o flags that fetch must be served next.
module starve_counter #(
  parameter int unsigned MaxCount = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic sat_o
);

  localparam int unsigned CntW = $clog2(MaxCount + 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  assign sat_o = (cnt_q == CntW'(MaxCount));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between fetch (read-only) and load/store.
// LS has priority, bounded by a starvation counter that forces a fetch grant.
module mem_port_arbiter
  import riscv_defs::*;
#(
  parameter int unsigned AddrWidth  = ADDR_W,
  parameter int unsigned DataWidth  = DATA_W,
  parameter int unsigned LsMaxBurst = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 if_req_i,
  input  logic [AddrWidth-1:0] if_addr_i,
  output logic                 if_gnt_o,
  output logic                 if_rsp_valid_o,
  output logic [DataWidth-1:0] if_rdata_o,
  input  logic                 ls_req_i,
  input  logic                 ls_we_i,
  input  logic [AddrWidth-1:0] ls_addr_i,
  input  logic [DataWidth-1:0] ls_wdata_i,
  output logic                 ls_gnt_o,
  output logic                 ls_rsp_valid_o,
  output logic [DataWidth-1:0] ls_rdata_o,
  output logic                 mem_en_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic [DataWidth-1:0] mem_rdata_i
);

  owner_e owner_q;
  owner_e owner_d;
  logic   sat;
  logic   if_win;
  logic   ls_win;

  assign if_win = rst_ni & if_req_i & (~ls_req_i | sat);
  assign ls_win = rst_ni & ls_req_i & ~if_win;

  assign if_gnt_o = if_win;
  assign ls_gnt_o = ls_win;

  starve_counter #(
    .MaxCount (LsMaxBurst)
  ) u_starve (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (if_win | ~if_req_i),
    .inc_i  (ls_win & if_req_i),
    .sat_o  (sat)
  );

  always_comb begin
    owner_d     = OWN_NONE;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (1'b1)
      if_win: begin
        owner_d    = OWN_IF;
        mem_en_o   = 1'b1;
        mem_addr_o = if_addr_i;
      end
      ls_win: begin
        owner_d     = ls_we_i ? OWN_LS_WR : OWN_LS_RD;
        mem_en_o    = 1'b1;
        mem_we_o    = ls_we_i;
        mem_addr_o  = ls_addr_i;
        mem_wdata_o = ls_we_i ? ls_wdata_i : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Gating with rst_ni drops a response whose grant is being reset away.
  assign if_rsp_valid_o = rst_ni & (owner_q == OWN_IF);
  assign ls_rsp_valid_o = rst_ni & owner_is_ls(owner_q);

  assign if_rdata_o = if_rsp_valid_o ? mem_rdata_i : '0;
  assign ls_rdata_o = (ls_rsp_valid_o && owner_q == OWN_LS_RD)
                    ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed plan plus random traffic.
// Reference model predicts grants and read data; monitor checks responses.
module tb_mem_port_arbiter;
  import riscv_defs::*;

  localparam int MB = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_gnt, if_rsp_valid;
  logic [15:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rsp_valid;
  logic [15:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AddrWidth (16),
    .DataWidth (16),
    .LsMaxBurst(MB)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .if_req_i      (if_req),
    .if_addr_i     (if_addr),
    .if_gnt_o      (if_gnt),
    .if_rsp_valid_o(if_rsp_valid),
    .if_rdata_o    (if_rdata),
    .ls_req_i      (ls_req),
    .ls_we_i       (ls_we),
    .ls_addr_i     (ls_addr),
    .ls_wdata_i    (ls_wdata),
    .ls_gnt_o      (ls_gnt),
    .ls_rsp_valid_o(ls_rsp_valid),
    .ls_rdata_o    (ls_rdata),
    .mem_en_o      (mem_en),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata)
  );

  logic [15:0] ram    [256];
  logic [15:0] shadow [256];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  typedef struct {
    int          tag;
    logic [15:0] data;
  } exp_t;

  exp_t if_q[$];
  exp_t ls_q[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int streak = 0;
  bit if_taken, ls_taken;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: grant rules, starvation bound, RAM contents.
  always @(negedge clk) begin
    bit ei, el;
    if (!rst_n) begin
      check("rst_if_gnt", if_gnt, 0);
      check("rst_ls_gnt", ls_gnt, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      streak = 0;
    end else begin
      ei = if_req && (!ls_req || streak == MB);
      el = ls_req && !ei;
      check("if_gnt", if_gnt, 32'(ei));
      check("ls_gnt", ls_gnt, 32'(el));
      check("mem_en", mem_en, 32'(ei || el));
      if (ei) begin
        check("if_mem_addr", mem_addr, if_addr);
        check("if_mem_we", mem_we, 0);
        check("if_mem_wdata", mem_wdata, 0);
        if_q.push_back('{cyc + 1, shadow[if_addr[7:0]]});
      end
      if (el) begin
        check("ls_mem_addr", mem_addr, ls_addr);
        check("ls_mem_we", mem_we, 32'(ls_we));
        if (ls_we) begin
          check("ls_mem_wdata", mem_wdata, ls_wdata);
          shadow[ls_addr[7:0]] = ls_wdata;
          ls_q.push_back('{cyc + 1, 16'h0});
        end else begin
          ls_q.push_back('{cyc + 1, shadow[ls_addr[7:0]]});
        end
      end
      if (ei || !if_req) streak = 0;
      else if (el && streak < MB) streak++;
    end
    if_taken = if_gnt;
    ls_taken = ls_gnt;
  end

  // Monitor: each response must appear exactly one cycle after its grant.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      while (if_q.size() > 0 && if_q[0].tag <= cyc) void'(if_q.pop_front());
      while (ls_q.size() > 0 && ls_q[0].tag <= cyc) void'(ls_q.pop_front());
      check("rst_if_rsp", if_rsp_valid, 0);
      check("rst_ls_rsp", ls_rsp_valid, 0);
    end else begin
      if (if_q.size() > 0 && if_q[0].tag == cyc) begin
        e = if_q.pop_front();
        check("if_rsp_valid", if_rsp_valid, 1);
        check("if_rdata", if_rdata, e.data);
      end else begin
        check("if_rsp_idle", if_rsp_valid, 0);
        check("if_rdata_idle", if_rdata, 0);
      end
      if (ls_q.size() > 0 && ls_q[0].tag == cyc) begin
        e = ls_q.pop_front();
        check("ls_rsp_valid", ls_rsp_valid, 1);
        check("ls_rdata", ls_rdata, e.data);
      end else begin
        check("ls_rsp_idle", ls_rsp_valid, 0);
        check("ls_rdata_idle", ls_rdata, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 0;
    ls_req = 0;
    ls_we  = 0;
    step();
  endtask

  bit pat[10] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 16'(i * 16'h0101 ^ 16'h5A3C);
      shadow[i] = ram[i];
    end
    ram[5]    = 16'h1234;
    shadow[5] = 16'h1234;
    mem_rdata = 16'h0;

    // Reset with both requesters active
    rst_n = 0; if_req = 1; if_addr = 16'd3;
    ls_req = 1; ls_we = 0; ls_addr = 16'd4; ls_wdata = 16'h0;
    step(); step();
    check("rst_owner", dut.owner_q, OWN_NONE);
    check("rst_cnt", dut.u_starve.cnt_q, 0);
    rst_n = 1;
    @(negedge clk);
    check("first_gnt", {30'b0, if_gnt, ls_gnt}, 32'b01);
    step();
    idle();

    // Fetch only
    if_req = 1; if_addr = 16'd5;
    @(negedge clk);
    check("fetch_gnt", if_gnt, 1);
    check("fetch_addr", mem_addr, 16'd5);
    check("fetch_we", mem_we, 0);
    step();
    if_req = 0;
    @(negedge clk);
    check("fetch_rsp", if_rsp_valid, 1);
    check("fetch_data", if_rdata, 16'h1234);
    check("fetch_no_ls", ls_rsp_valid, 0);
    step();
    idle();

    // Contention: LS x3 then forced IF
    if_req = 1; ls_req = 1; ls_we = 0;
    for (int i = 0; i < 10; i++) begin
      if_addr = 16'(20 + i);
      ls_addr = 16'(40 + i);
      @(negedge clk);
      check("cont_if_gnt", if_gnt, 32'(pat[i]));
      check("cont_ls_gnt", ls_gnt, 32'(!pat[i]));
      step();
    end
    idle();
    idle();

    // Store then load to the same word
    ls_req = 1; ls_we = 1; ls_addr = 16'd9; ls_wdata = 16'hBEEF;
    @(negedge clk);
    check("store_gnt", ls_gnt, 1);
    step();
    ls_we = 0;
    @(negedge clk);
    check("store_ack", ls_rsp_valid, 1);
    check("store_ack_data", ls_rdata, 0);
    step();
    ls_req = 0;
    @(negedge clk);
    check("load_rsp", ls_rsp_valid, 1);
    check("load_data", ls_rdata, 16'hBEEF);
    step();
    idle();

    // Reset while a fetch response is pending
    if_req = 1; if_addr = 16'd5;
    @(negedge clk);
    check("mid_gnt", if_gnt, 1);
    step();
    if_req = 0; rst_n = 0;
    @(negedge clk);
    check("mid_no_rsp", if_rsp_valid, 0);
    step();
    check("mid_owner", dut.owner_q, OWN_NONE);
    check("mid_cnt", dut.u_starve.cnt_q, 0);
    rst_n = 1;
    idle();

    // Withdrawn LS pulse while IF holds priority
    if_req = 1; if_addr = 16'd7; ls_req = 1; ls_we = 0;
    for (int i = 0; i < MB; i++) begin
      ls_addr = 16'(60 + i);
      step();
    end
    ls_addr = 16'd70;
    @(negedge clk);
    check("wd_if_gnt", if_gnt, 1);
    check("wd_ls_gnt", ls_gnt, 0);
    step();
    if_req = 0; ls_req = 0;
    step();
    check("wd_cnt", dut.u_starve.cnt_q, 0);
    idle();

    // Random traffic with occasional withdraws and resets
    for (int n = 0; n < 3000; n++) begin
      if (!if_req || if_taken) begin
        if_req  = ($urandom_range(0, 9) < 6);
        if_addr = 16'($urandom_range(0, 255));
      end else if ($urandom_range(0, 19) == 0) begin
        if_req = 0;
      end
      if (!ls_req || ls_taken) begin
        ls_req   = ($urandom_range(0, 9) < 7);
        ls_we    = $urandom_range(0, 2) == 0;
        ls_addr  = 16'($urandom_range(0, 255));
        ls_wdata = 16'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        ls_req = 0;
      end
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1;
    idle();
    idle();
    idle();
    check("drain", if_q.size() + ls_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 16-bit data/instruction RAM between the instruction-fetch stage (read-only) and the load/store stage (read/write) of the RISCV core.
- Arbitrates every cycle.
- Drives the RAM port and routes each 1-cycle-latency read response back to its owner.
- A starvation counter bounds how long fetch can be blocked by back-to-back load/store traffic.

Parameters:
- AddrWidth, 16, RAM word-address width.
- DataWidth, 16, RAM word width.
- LsMaxBurst, 3, maximum consecutive LS grants while IF is waiting; must be ≥1.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Rst_n  in  1  synchronous active-low reset.
- IfReq  in  1  fetch request; held stable until IfGnt.
- IfAddr  in  AddrWidth  fetch word address.
- IfGnt  out  1  fetch accepted this cycle.
- IfRspValid  out  1  IfRdata valid this cycle.
- IfRdata  out  DataWidth  fetched instruction word.
- LsReq  in  1  load/store request; held stable until LsGnt.
- LsWe  in  1  1 = store, 0 = load.
- LsAddr  in  AddrWidth  load/store word address.
- LsWdata  in  DataWidth  store data.
- LsGnt  out  1  load/store accepted this cycle.
- LsRspValid  out  1  load data valid, or store acknowledged.
- LsRdata  out  DataWidth  load data; 0 for store acknowledge.
- MemEn  out  1  RAM access this cycle.
- MemWe  out  1  RAM write strobe.
- MemAddr  out  AddrWidth  RAM address.
- MemWdata  out  DataWidth  RAM write data.
- MemRdata  in  DataWidth  RAM read data, valid the cycle after MemEn & !MemWe.

Behaviour:
- Reset: while Rst_n = 0 at a rising edge:
  - Owner ← NONE, StarveCnt ← 0.
  - While Rst_n is low: IfGnt, LsGnt and MemEn are forced to 0; MemWe, MemAddr and MemWdata are 0.
  - Resp outputs are 0 in the cycle after any reset edge.
- Arbitration (combinational, same cycle):
  - Only IfReq → IF wins.
  - Only LsReq → LS wins.
  - Both requesting → LS wins, unless StarveCnt == LsMaxBurst, in which case IF wins.
  - Neither → no grant, MemEn = 0.
- At most one grant per cycle; the granted request drives MemEn = 1 and MemAddr/MemWe/MemWdata in the same cycle. IF grant forces MemWe = 0 and MemWdata = 0.
- Owner register (2-bit state: NONE, IF, LS_RD, LS_WR) loads the winner of the current cycle (NONE if no grant) at every edge.
- Responses, issued one cycle after the grant:
  - IfRspValid = (Owner == IF); IfRdata = MemRdata when valid, else 0.
  - LsRspValid = (Owner == LS_RD or LS_WR); LsRdata = MemRdata if LS_RD, else 0.
- Throughput: fully pipelined; a new grant may issue in the same cycle as the previous response. Back-to-back grants to the same requester are allowed.
- StarveCnt, width clog2(LsMaxBurst+1), updated at each edge:
  - LS granted and IfReq = 1 → saturating increment.
  - IF granted, or IfReq = 0 → 0.
  - Otherwise → hold.
- Requester protocol: Req/Addr/We/Wdata must stay stable until Gnt. Dropping Req before Gnt is permitted and simply withdraws the request.
- Store ordering: store then load to the same address on consecutive cycles returns the new data, per RAM write-first semantics.
- Reset mid-operation: a pending response is discarded and no RspValid is produced for it.

Decomposition:
- Shared package/header `riscv_defs`:
  - Owner encodings: OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_LS_RD = 2'd2, OWN_LS_WR = 2'd3.
  - Default AddrWidth/DataWidth constants, reused by the core and the RAM.
- One natural sub-module: `starve_counter` (saturating counter with clear, increment and saturation flag).
- Arbitration and response routing stay in the top module.

Test Plan:
- Reset: Rst_n = 0 for 2 cycles with IfReq = LsReq = 1 → IfGnt = LsGnt = MemEn = 0, no RspValid. Release → first grant goes to LS.
- Fetch only: RAM[5] = 16'h1234; IfReq = 1, IfAddr = 5 → IfGnt = 1 with MemAddr = 5, MemWe = 0; next cycle IfRspValid = 1, IfRdata = 16'h1234, LsRspValid = 0.
- Contention/starvation: IfReq and LsReq both held high for 10 cycles, LsMaxBurst = 3 → grant sequence LS, LS, LS, IF, LS, LS, LS, IF, LS, LS; each response appears on the matching port one cycle later.
- Store then load: LsWe = 1, LsAddr = 9, LsWdata = 16'hBEEF, then load from 9 → store ack LsRspValid = 1, LsRdata = 0; next cycle load returns 16'hBEEF.
- Reset mid-flight: grant IF load at cycle N, Rst_n = 0 at edge N+1 → IfRspValid = 0 at cycle N+1; Owner = NONE, StarveCnt = 0.
- Withdrawn request: LsReq pulsed for 1 cycle while IF holds priority (StarveCnt = LsMaxBurst) → LS never granted, no LsRspValid, StarveCnt clears after the IF grant.
